// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_pkg
//  Description : Shared constants and types for the 100GBASE-R receive PCS:
//                alignment-marker table, AM sync header and the AM lock
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcs_pkg;

    // Number of entries in the alignment-marker table (one per PCS lane)
    localparam int AM_TABLE_SIZE = 20;

    // Sync header carried by an alignment marker (control block)
    localparam logic [1:0] AM_SH = 2'b10;

    // {M0,M1,M2} for each PCS lane, IEEE 802.3 Table 82-2
    localparam logic [23:0] AM_TABLE [AM_TABLE_SIZE] = '{
        24'hC16821,  // lane 0
        24'h9D718E,  // lane 1
        24'h594BE8,  // lane 2
        24'h4D957B,  // lane 3
        24'hF50709,  // lane 4
        24'hDD14C2,  // lane 5
        24'h9A4A26,  // lane 6
        24'h7B4566,  // lane 7
        24'hA02476,  // lane 8
        24'h68C9FB,  // lane 9
        24'hFD6C99,  // lane 10
        24'hB99155,  // lane 11
        24'h5CB9B2,  // lane 12
        24'h1AF8BD,  // lane 13
        24'h83C7CA,  // lane 14
        24'h3536CD,  // lane 15
        24'hC4314C,  // lane 16
        24'hADD6B7,  // lane 17
        24'h5F662A,  // lane 18
        24'hC0F0E5   // lane 19
    };

    // AM lock FSM states; the COMP_* states are evaluated inside
    // COUNT_1/LOCKED on the slot cycle and are never held as a register value
    typedef enum logic [2:0] {
        LOCK_INIT = 3'd0,
        FIND_1ST  = 3'd1,
        COUNT_1   = 3'd2,
        COMP_2ND  = 3'd3,
        LOCKED    = 3'd4,
        COMP_AM   = 3'd5
    } am_lock_state_e;

endpackage
`default_nettype wire

// File: rtl/am_lock_lane_if.sv
`default_nettype none
// ============================================================================
//  Module      : am_lock_lane_if
//  Description : Lane stream bundle of the AM lock stage: incoming block
//                stream with block-lock status, and the delayed stream with
//                lock status, lane ID and deskew strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface am_lock_lane_if #(
    parameter int NB_DATA    = 66,
    parameter int NB_LANE_ID = 5
);

    logic                  i_valid;
    logic                  i_block_lock;
    logic [NB_DATA-1:0]    i_data;
    logic [NB_DATA-1:0]    o_data;
    logic                  o_valid;
    logic                  o_start_of_lane;
    logic                  o_resync;
    logic                  o_am_lock;
    logic [NB_LANE_ID-1:0] o_lane_id;

    // Upstream side: drives the received blocks, observes the lock stage
    modport master (
        output i_valid, i_block_lock, i_data,
        input  o_data, o_valid, o_start_of_lane, o_resync, o_am_lock, o_lane_id
    );

    // Lock stage side
    modport slave (
        input  i_valid, i_block_lock, i_data,
        output o_data, o_valid, o_start_of_lane, o_resync, o_am_lock, o_lane_id
    );

endinterface
`default_nettype wire

// File: rtl/am_match.sv
`default_nettype none
// ============================================================================
//  Module      : am_match
//  Description : Combinational alignment-marker detector. Flags a block whose
//                sync header, {M0,M1,M2} and complemented {M4,M5,M6} form a
//                valid AM and returns the index of the matching lane entry.
//                BIP3/BIP7 are parity bytes and take no part in the match.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_match
    import pcs_pkg::*;
#(
    parameter int NB_DATA    = 66,
    parameter int N_LANES    = 20,
    parameter int NB_LANE_ID = $clog2(N_LANES)
) (
    input  wire logic [NB_DATA-1:0]    i_data,
    output logic                       am_hit,
    output logic [NB_LANE_ID-1:0]      am_id
);

    logic [1:0]  w_sh;
    logic [23:0] w_m012;
    logic [23:0] w_m456;
    logic        w_fmt_ok;
    logic        w_unused;

    assign w_sh     = i_data[65:64];
    assign w_m012   = i_data[63:40];
    assign w_m456   = i_data[31:8];
    assign w_fmt_ok = (w_sh == AM_SH) && (w_m456 == ~w_m012);

    // Parity bytes are deliberately not inspected
    assign w_unused = ^{i_data[39:32], i_data[7:0]};

    // Search the lane table for the received marker pattern
    always_comb begin
        am_hit = 1'b0;
        am_id  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (w_fmt_ok && (w_m012 == AM_TABLE[i])) begin
                am_hit = 1'b1;
                am_id  = NB_LANE_ID'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/am_lock_lane.sv
`default_nettype none
// ============================================================================
//  Module      : am_lock_lane
//  Description : Per-lane alignment-marker lock. Hunts for an AM, confirms a
//                second AM of the same lane one period later, then tracks the
//                marker at every period. Emits start-of-lane and resync
//                strobes aligned with the delayed block stream, and the
//                logical lane ID of the locked marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_lock_lane
    import pcs_pkg::*;
#(
    parameter int NB_DATA    = 66,
    parameter int N_LANES    = 20,
    parameter int AM_PERIOD  = 16384,
    parameter int MAX_INV_AM = 4,
    parameter int NB_LANE_ID = $clog2(N_LANES)
) (
    input  wire logic     i_clock,
    input  wire logic     i_reset,
    input  wire logic     i_enable,
    am_lock_lane_if.slave lane_if
);

    localparam int                     c_NB_CNT  = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    localparam int                     c_NB_INV  = $clog2(MAX_INV_AM + 1);
    localparam logic [c_NB_CNT-1:0]    c_SLOT    = c_NB_CNT'(AM_PERIOD - 1);
    localparam logic [c_NB_INV-1:0]    c_MAX_INV = c_NB_INV'(MAX_INV_AM);

    logic                   w_am_hit;
    logic [NB_LANE_ID-1:0]  w_am_id;
    logic                   w_am_slot;
    logic                   w_cand_match;
    logic                   w_good_am;
    logic [c_NB_INV-1:0]    w_inv_cnt_inc;

    am_lock_state_e         r_state;
    am_lock_state_e         w_state_next;
    logic [c_NB_CNT-1:0]    r_blk_cnt;
    logic [c_NB_CNT-1:0]    w_blk_cnt_next;
    logic [c_NB_INV-1:0]    r_inv_cnt;
    logic [c_NB_INV-1:0]    w_inv_cnt_next;
    logic [NB_LANE_ID-1:0]  r_cand_id;
    logic [NB_LANE_ID-1:0]  w_cand_id_next;
    logic                   r_am_lock;
    logic                   w_am_lock_next;
    logic [NB_LANE_ID-1:0]  r_lane_id;
    logic [NB_LANE_ID-1:0]  w_lane_id_next;
    logic                   r_start_of_lane;
    logic                   w_start_of_lane_next;
    logic                   r_resync;
    logic                   w_resync_next;
    logic [NB_DATA-1:0]     r_data;
    logic                   r_valid;

    am_match #(
        .NB_DATA    (NB_DATA),
        .N_LANES    (N_LANES),
        .NB_LANE_ID (NB_LANE_ID)
    ) u_am_match (
        .i_data (lane_if.i_data),
        .am_hit (w_am_hit),
        .am_id  (w_am_id)
    );

    // Slot is the last valid block of a period; compares happen only there
    assign w_am_slot     = lane_if.i_valid && (r_blk_cnt == c_SLOT);
    assign w_cand_match  = w_am_hit && (w_am_id == r_cand_id);
    assign w_good_am     = w_am_hit && (w_am_id == r_lane_id);
    assign w_inv_cnt_inc = r_inv_cnt + 1'b1;

    // Next-state and output decisions; everything holds while disabled
    always_comb begin
        w_state_next         = r_state;
        w_blk_cnt_next       = r_blk_cnt;
        w_inv_cnt_next       = r_inv_cnt;
        w_cand_id_next       = r_cand_id;
        w_am_lock_next       = r_am_lock;
        w_lane_id_next       = r_lane_id;
        w_start_of_lane_next = 1'b0;
        w_resync_next        = 1'b0;

        if (i_enable) begin
            // Block counter runs on valid blocks and wraps after the slot
            if (lane_if.i_valid) begin
                w_blk_cnt_next = w_am_slot ? '0 : r_blk_cnt + 1'b1;
            end

            if (!lane_if.i_block_lock) begin
                // Block-lock loss overrides any slot decision this cycle
                w_state_next   = LOCK_INIT;
                w_blk_cnt_next = '0;
                w_inv_cnt_next = '0;
                w_am_lock_next = 1'b0;
                w_resync_next  = r_am_lock;
            end else begin
                case (r_state)
                    LOCK_INIT: begin
                        w_state_next   = FIND_1ST;
                        w_blk_cnt_next = '0;
                    end
                    FIND_1ST: begin
                        if (lane_if.i_valid && w_am_hit) begin
                            w_cand_id_next = w_am_id;
                            w_blk_cnt_next = '0;
                            w_state_next   = COUNT_1;
                        end
                    end
                    COUNT_1: begin
                        // Second-AM confirmation on the slot block
                        if (w_am_slot) begin
                            if (w_cand_match) begin
                                w_state_next         = LOCKED;
                                w_am_lock_next       = 1'b1;
                                w_lane_id_next       = r_cand_id;
                                w_start_of_lane_next = 1'b1;
                                w_inv_cnt_next       = '0;
                            end else begin
                                w_state_next = FIND_1ST;
                            end
                        end
                    end
                    LOCKED: begin
                        // Per-period AM check on the slot block
                        if (w_am_slot) begin
                            if (w_good_am) begin
                                w_start_of_lane_next = 1'b1;
                                w_inv_cnt_next       = '0;
                            end else if (w_inv_cnt_inc >= c_MAX_INV) begin
                                w_state_next   = FIND_1ST;
                                w_am_lock_next = 1'b0;
                                w_resync_next  = 1'b1;
                                w_inv_cnt_next = '0;
                            end else begin
                                w_inv_cnt_next = w_inv_cnt_inc;
                            end
                        end
                    end
                    default: begin
                        w_state_next = LOCK_INIT;
                    end
                endcase
            end
        end
    end

    // FSM, counters and registered lock outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= LOCK_INIT;
            r_blk_cnt       <= '0;
            r_inv_cnt       <= '0;
            r_cand_id       <= '0;
            r_am_lock       <= 1'b0;
            r_lane_id       <= '0;
            r_start_of_lane <= 1'b0;
            r_resync        <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_blk_cnt       <= w_blk_cnt_next;
            r_inv_cnt       <= w_inv_cnt_next;
            r_cand_id       <= w_cand_id_next;
            r_am_lock       <= w_am_lock_next;
            r_lane_id       <= w_lane_id_next;
            r_start_of_lane <= w_start_of_lane_next;
            r_resync        <= w_resync_next;
        end
    end

    // One-cycle data pipeline so strobes line up with the AM block
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_enable) begin
            r_data  <= lane_if.i_data;
            r_valid <= lane_if.i_valid;
        end
    end

    assign lane_if.o_data          = r_data;
    assign lane_if.o_valid         = r_valid;
    assign lane_if.o_start_of_lane = r_start_of_lane;
    assign lane_if.o_resync        = r_resync;
    assign lane_if.o_am_lock       = r_am_lock;
    assign lane_if.o_lane_id       = r_lane_id;

endmodule
`default_nettype wire

// File: tb/tb_am_lock_lane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_lock_lane
//  Description : Directed self-checking bench for am_lock_lane with a short
//                AM period (16 blocks) and a 4-bad-AM lock-loss threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am_lock_lane;

    localparam int NB_DATA    = 66;
    localparam int NB_LANE_ID = 5;

    // {M0,M1,M2} for the lanes exercised here
    localparam logic [23:0] LANE0_M = 24'hC16821;
    localparam logic [23:0] LANE1_M = 24'h9D718E;
    localparam logic [23:0] LANE7_M = 24'h7B4566;

    logic tb_clock = 1'b0;
    logic reset_n;
    logic enable;

    int n_checks = 0;
    int n_errors = 0;

    logic [65:0] am0, am1, am7, bad_sh, bad_cmp, bad_hdr3, blk;

    am_lock_lane_if #(.NB_DATA(NB_DATA), .NB_LANE_ID(NB_LANE_ID)) lane_if ();

    am_lock_lane #(
        .NB_DATA    (NB_DATA),
        .N_LANES    (20),
        .AM_PERIOD  (16),
        .MAX_INV_AM (4),
        .NB_LANE_ID (NB_LANE_ID)
    ) dut (
        .i_clock  (tb_clock),
        .i_reset  (reset_n),
        .i_enable (enable),
        .lane_if  (lane_if)
    );

    always #5 tb_clock = ~tb_clock;

    task automatic check_value(input string tag, input logic [65:0] actual, input logic [65:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [65:0] mk_am(input logic [23:0] m);
        logic [7:0] bip3, bip7;
        bip3 = 8'($urandom());
        bip7 = 8'($urandom());
        return {2'b10, m, bip3, ~m, bip7};
    endfunction

    function automatic logic [65:0] rnd_blk();
        return {2'b01, $urandom(), $urandom()};
    endfunction

    // Drive one block, clock it, check everything that comes out with it
    task automatic send(input string tag, input logic v, input logic [65:0] d,
                        input logic e_sol, input logic e_rs, input logic e_lock);
        lane_if.i_valid = v;
        lane_if.i_data  = d;
        @(posedge tb_clock);
        #1;
        check_value({tag, ".data"},  lane_if.o_data, d);
        check_value({tag, ".valid"}, lane_if.o_valid, v);
        check_value({tag, ".sol"},   lane_if.o_start_of_lane, e_sol);
        check_value({tag, ".rs"},    lane_if.o_resync, e_rs);
        check_value({tag, ".lock"},  lane_if.o_am_lock, e_lock);
    endtask

    task automatic fill(input int n, input logic e_lock);
        for (int k = 0; k < n; k++) send("fill", 1'b1, rnd_blk(), 1'b0, 1'b0, e_lock);
    endtask

    // 15 data blocks then the slot block
    task automatic period(input string tag, input logic [65:0] slot_blk, input logic e_sol,
                          input logic e_rs, input logic lock_before, input logic lock_after);
        fill(15, lock_before);
        send(tag, 1'b1, slot_blk, e_sol, e_rs, lock_after);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, ".data"},  lane_if.o_data, 66'd0);
        check_value({tag, ".valid"}, lane_if.o_valid, 1'b0);
        check_value({tag, ".sol"},   lane_if.o_start_of_lane, 1'b0);
        check_value({tag, ".rs"},    lane_if.o_resync, 1'b0);
        check_value({tag, ".lock"},  lane_if.o_am_lock, 1'b0);
        check_value({tag, ".id"},    lane_if.o_lane_id, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n              = 1'b0;
        enable               = 1'b1;
        lane_if.i_valid      = 1'b0;
        lane_if.i_block_lock = 1'b1;
        lane_if.i_data       = '0;
        am0      = mk_am(LANE0_M);
        am1      = mk_am(LANE1_M);
        am7      = mk_am(LANE7_M);
        bad_sh   = {2'b01, am0[63:0]};
        bad_cmp  = am0 ^ (66'hFF << 24);
        bad_hdr3 = {2'b11, am0[63:0]};

        repeat (3) @(posedge tb_clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // ---- lane-0 acquisition and tracking ----
        send("s1_idle", 1'b0, 66'd0, 1'b0, 1'b0, 1'b0);
        send("s1_am_first", 1'b1, am0, 1'b0, 1'b0, 1'b0);
        period("s1_lock", am0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_value("s1_lane_id", lane_if.o_lane_id, 5'd0);
        period("s1_track1", am0, 1'b1, 1'b0, 1'b1, 1'b1);
        period("s1_track2", am0, 1'b1, 1'b0, 1'b1, 1'b1);

        // ---- enable low: outputs frozen, strobe forced low ----
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lane_if.i_valid = 1'b1;
            lane_if.i_data  = rnd_blk();
            @(posedge tb_clock);
            #1;
            check_value("dis.data", lane_if.o_data, am0);
            check_value("dis.sol",  lane_if.o_start_of_lane, 1'b0);
            check_value("dis.lock", lane_if.o_am_lock, 1'b1);
        end
        enable = 1'b1;
        period("s1_after_dis", am0, 1'b1, 1'b0, 1'b1, 1'b1);

        // ---- async reset mid-period ----
        fill(5, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("areset1");
        @(posedge tb_clock);
        #1;
        reset_n = 1'b1;

        // ---- mismatched second AM falls back to hunting ----
        send("s2_idle", 1'b0, 66'd0, 1'b0, 1'b0, 1'b0);
        send("s2_am1", 1'b1, am1, 1'b0, 1'b0, 1'b0);
        period("s2_mismatch", am0, 1'b0, 1'b0, 1'b0, 1'b0);
        period("s2_first", am0, 1'b0, 1'b0, 1'b0, 1'b0);
        period("s2_lock", am0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_value("s2_lane_id", lane_if.o_lane_id, 5'd0);

        // ---- three bad AMs then a good one: lock held ----
        period("s3_bad1", bad_sh, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s3_bad2", bad_cmp, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s3_bad3", am1, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s3_good", am0, 1'b1, 1'b0, 1'b1, 1'b1);

        // ---- four bad AMs: lock lost, then relock ----
        period("s4_bad1", bad_cmp, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s4_bad2", am1, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s4_bad3", bad_sh, 1'b0, 1'b0, 1'b1, 1'b1);
        period("s4_bad4", bad_hdr3, 1'b0, 1'b1, 1'b1, 1'b0);
        period("s4_first", am0, 1'b0, 1'b0, 1'b0, 1'b0);
        period("s4_relock", am0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_value("s4_lane_id", lane_if.o_lane_id, 5'd0);

        // ---- invalid gaps and a stray AM inside the period ----
        for (int k = 0; k < 15; k++) begin
            if (k == 2 || k == 5 || k == 6 || k == 10 || k == 13)
                send("s5_gap", 1'b0, rnd_blk(), 1'b0, 1'b0, 1'b1);
            blk = (k == 7) ? am0 : rnd_blk();
            send("s5_dat", 1'b1, blk, 1'b0, 1'b0, 1'b1);
        end
        send("s5_slot", 1'b1, am0, 1'b1, 1'b0, 1'b1);

        // ---- block-lock loss mid-period ----
        fill(6, 1'b1);
        lane_if.i_block_lock = 1'b0;
        send("s6_drop", 1'b1, rnd_blk(), 1'b0, 1'b1, 1'b0);
        send("s6_after", 1'b1, rnd_blk(), 1'b0, 1'b0, 1'b0);
        lane_if.i_block_lock = 1'b1;
        send("s6_idle", 1'b0, 66'd0, 1'b0, 1'b0, 1'b0);
        send("s6_am7", 1'b1, am7, 1'b0, 1'b0, 1'b0);
        period("s6_lock7", am7, 1'b1, 1'b0, 1'b0, 1'b1);
        check_value("s6_lane_id7", lane_if.o_lane_id, 5'd7);

        // ---- block-lock loss on the slot wins over a good AM ----
        fill(15, 1'b1);
        lane_if.i_block_lock = 1'b0;
        send("s7_slotdrop", 1'b1, am7, 1'b0, 1'b1, 1'b0);
        lane_if.i_block_lock = 1'b1;
        send("s7_idle", 1'b0, 66'd0, 1'b0, 1'b0, 1'b0);
        send("s7_am7", 1'b1, am7, 1'b0, 1'b0, 1'b0);
        period("s7_relock", am7, 1'b1, 1'b0, 1'b0, 1'b1);
        check_value("s7_lane_id7", lane_if.o_lane_id, 5'd7);

        // ---- async reset while locked: immediate clear, no resync ----
        fill(7, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("areset2");
        @(posedge tb_clock);
        #1;
        check_reset_outputs("areset2_hold");
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
